// File: rtl/frame_ram_arbiter_pkg.sv
// Shared constants and types for the frame RAM and its arbiter.
// Also imported by the image engine so everything agrees on RAM geometry.
package frame_ram_arbiter_pkg;

    localparam int N_REQ     = 3;
    localparam int DATA_W    = 8;
    localparam int ADDR_W    = 17;
    localparam int DEPTH     = 76800;
    localparam int RD_LAT    = 1;
    localparam int BURST_MAX = 16;
    localparam int IDX_W     = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W     = $clog2(BURST_MAX + 1);

    typedef enum logic [0:0] {
        ARB_IDLE = 1'b0,
        ARB_OWN  = 1'b1
    } arb_state_e;

    // One entry of the read-return pipeline; valid marks an accepted read.
    typedef struct packed {
        logic             valid;
        logic             oor;
        logic [IDX_W-1:0] idx;
    } tag_t;

    function automatic logic [IDX_W-1:0] idx_inc(input logic [IDX_W-1:0] i);
        return (i == IDX_W'(N_REQ - 1)) ? '0 : i + 1'b1;
    endfunction

endpackage

// File: rtl/frame_ram_arbiter_if.sv
// Requester-side and RAM-side signals of the frame RAM arbiter.
// Handshake: an access is accepted in any cycle where req_i[k] and gnt_o[k] are both 1.
interface frame_ram_arbiter_if
    import frame_ram_arbiter_pkg::*;
    ();

    logic [N_REQ-1:0]        req_i;
    logic [N_REQ-1:0]        we_i;
    logic [N_REQ*ADDR_W-1:0] addr_i;
    logic [N_REQ*DATA_W-1:0] wdata_i;
    logic [N_REQ-1:0]        gnt_o;
    logic [N_REQ-1:0]        rvalid_o;
    logic [DATA_W-1:0]       rdata_o;
    logic [N_REQ-1:0]        err_o;
    logic                    ram_en_o;
    logic                    ram_we_o;
    logic [ADDR_W-1:0]       ram_addr_o;
    logic [DATA_W-1:0]       ram_wdata_o;
    logic [DATA_W-1:0]       ram_rdata_i;
    logic                    busy_o;
    arb_state_e              arb_state;

    modport slave (
        input  req_i, we_i, addr_i, wdata_i, ram_rdata_i,
        output gnt_o, rvalid_o, rdata_o, err_o,
        output ram_en_o, ram_we_o, ram_addr_o, ram_wdata_o, busy_o, arb_state
    );

    modport master (
        output req_i, we_i, addr_i, wdata_i, ram_rdata_i,
        input  gnt_o, rvalid_o, rdata_o, err_o,
        input  ram_en_o, ram_we_o, ram_addr_o, ram_wdata_o, busy_o, arb_state
    );

endinterface

// File: rtl/frame_ram_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after start, wrapping.
module frame_ram_arbiter_rr_pick
    import frame_ram_arbiter_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] start,
    output logic [N_REQ-1:0] onehot,
    output logic [IDX_W-1:0] idx,
    output logic             found
);

    localparam logic [IDX_W:0] N_W = (IDX_W + 1)'(N_REQ);

    logic [N_REQ-1:0] rot;
    logic [IDX_W:0]   sum;

    // Rotating the doubled vector puts the start index at bit 0.
    assign rot = N_REQ'({req, req} >> start);

    always_comb begin
        found = 1'b0;
        idx   = '0;
        sum   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!found && rot[i]) begin
                found = 1'b1;
                sum   = {1'b0, start} + (IDX_W + 1)'(i);
                idx   = (sum >= N_W) ? IDX_W'(sum - N_W) : IDX_W'(sum);
            end
        end
        onehot = found ? (N_REQ'(1) << idx) : '0;
    end

endmodule

// File: rtl/frame_ram_arbiter.sv
// Round-robin arbiter with bounded bursts sharing one single-port frame RAM.
// Registered command stage; fixed-latency tagged read return; out-of-range trapping.
module frame_ram_arbiter
    import frame_ram_arbiter_pkg::*;
(
    input logic clk_i,
    input logic rstn_i,
    frame_ram_arbiter_if.slave bus
);

    localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W + 1)'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BURST_MAX);

    arb_state_e       state_q, state_d;
    logic [IDX_W-1:0] owner_q, owner_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [N_REQ-1:0] owner_oh;
    logic [N_REQ-1:0] pick_req;
    logic [IDX_W-1:0] pick_start;
    logic [N_REQ-1:0] pick_oh;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_found;
    logic             others;
    logic             keep;
    logic [N_REQ-1:0] gnt;

    assign owner_oh = N_REQ'(1) << owner_q;
    assign others   = |(bus.req_i & ~owner_oh);
    assign keep     = (state_q == ARB_OWN) && bus.req_i[owner_q] &&
                      ((cnt_q < CNT_MAX) || !others);

    // When owning, the owner is masked so a re-pick always moves on.
    assign pick_req   = (state_q == ARB_OWN) ? (bus.req_i & ~owner_oh) : bus.req_i;
    assign pick_start = (state_q == ARB_OWN) ? idx_inc(owner_q) : ptr_q;

    frame_ram_arbiter_rr_pick u_pick (
        .req    (pick_req),
        .start  (pick_start),
        .onehot (pick_oh),
        .idx    (pick_idx),
        .found  (pick_found)
    );

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        gnt     = '0;
        if (keep) begin
            gnt   = owner_oh;
            cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        end else if (pick_found) begin
            gnt     = pick_oh;
            state_d = ARB_OWN;
            owner_d = pick_idx;
            cnt_d   = CNT_W'(1);
            ptr_d   = idx_inc(pick_idx);
        end else begin
            state_d = ARB_IDLE;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= ARB_IDLE;
            owner_q <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    // Select the granted requester's slice.
    logic              acc;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic [IDX_W-1:0]  sel_idx;
    logic              oor;

    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        sel_idx   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (gnt[k]) begin
                sel_we    = bus.we_i[k];
                sel_addr  = bus.addr_i[k*ADDR_W +: ADDR_W];
                sel_wdata = bus.wdata_i[k*DATA_W +: DATA_W];
                sel_idx   = IDX_W'(k);
            end
        end
    end

    assign acc = |(gnt & bus.req_i);
    assign oor = ({1'b0, sel_addr} >= DEPTH_W);

    logic              ram_en_q;
    logic              ram_we_q;
    logic [ADDR_W-1:0] ram_addr_q;
    logic [DATA_W-1:0] ram_wdata_q;
    logic [N_REQ-1:0]  err_q;
    tag_t              tag_q [0:RD_LAT];

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            ram_en_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            err_q       <= '0;
            for (int i = 0; i <= RD_LAT; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            ram_en_q <= acc && !oor;
            if (acc && !oor) begin
                ram_we_q    <= sel_we;
                ram_addr_q  <= sel_addr;
                ram_wdata_q <= sel_wdata;
            end
            err_q    <= (acc && oor) ? gnt : '0;
            tag_q[0] <= '{valid: acc && !sel_we, oor: oor, idx: sel_idx};
            for (int i = 1; i <= RD_LAT; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    logic any_tag;

    always_comb begin
        any_tag = 1'b0;
        for (int i = 0; i <= RD_LAT; i++) begin
            any_tag = any_tag | tag_q[i].valid;
        end
    end

    assign bus.gnt_o       = gnt;
    assign bus.ram_en_o    = ram_en_q;
    assign bus.ram_we_o    = ram_we_q;
    assign bus.ram_addr_o  = ram_addr_q;
    assign bus.ram_wdata_o = ram_wdata_q;
    assign bus.err_o       = err_q;
    assign bus.rvalid_o    = tag_q[RD_LAT].valid ? (N_REQ'(1) << tag_q[RD_LAT].idx) : '0;
    assign bus.rdata_o     = (tag_q[RD_LAT].valid && !tag_q[RD_LAT].oor) ? bus.ram_rdata_i : '0;
    assign bus.busy_o      = ram_en_q | any_tag;
    assign bus.arb_state   = state_q;

endmodule

// File: tb/tb_frame_ram_arbiter.sv
// Directed bench for frame_ram_arbiter with a behavioural single-port RAM (one-cycle read).
module tb_frame_ram_arbiter;
    import frame_ram_arbiter_pkg::*;

    logic clk;
    logic rstn;
    int   tests;
    int   fails;

    frame_ram_arbiter_if bus ();

    frame_ram_arbiter dut (
        .clk_i  (clk),
        .rstn_i (rstn),
        .bus    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [DATA_W-1:0] mem [0:DEPTH-1];

    always @(posedge clk) begin
        if (bus.ram_en_o) begin
            if (bus.ram_we_o) mem[bus.ram_addr_o] <= bus.ram_wdata_o;
            else bus.ram_rdata_i <= mem[bus.ram_addr_o];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clr_all();
        bus.req_i   = '0;
        bus.we_i    = '0;
        bus.addr_i  = '0;
        bus.wdata_i = '0;
    endtask

    task automatic drive(input int k, input logic we, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] d);
        bus.req_i[k]                    = 1'b1;
        bus.we_i[k]                     = we;
        bus.addr_i[k*ADDR_W +: ADDR_W]  = a;
        bus.wdata_i[k*DATA_W +: DATA_W] = d;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench 1 time unit after a rising edge, ready to drive a cycle.
    task automatic do_reset();
        rstn = 1'b0;
        clr_all();
        @(negedge clk);
        chk("rst_gnt", 32'(bus.gnt_o), 0);
        chk("rst_rvalid", 32'(bus.rvalid_o), 0);
        chk("rst_err", 32'(bus.err_o), 0);
        chk("rst_ram_en", 32'(bus.ram_en_o), 0);
        chk("rst_busy", 32'(bus.busy_o), 0);
        chk("rst_state", 32'(bus.arb_state), 0);
        next_cycle();
        rstn = 1'b1;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        clr_all();
        do_reset();

        // Requester 1 writes 0..15 then reads them back.
        for (int t = 0; t < 16; t++) begin
            clr_all();
            drive(1, 1'b1, ADDR_W'(t), DATA_W'(t));
            @(negedge clk);
            chk("wr_gnt", 32'(bus.gnt_o), 32'b010);
            if (t > 0) begin
                chk("wr_en", 32'(bus.ram_en_o), 1);
                chk("wr_we", 32'(bus.ram_we_o), 1);
                chk("wr_addr", 32'(bus.ram_addr_o), 32'(t - 1));
                chk("wr_data", 32'(bus.ram_wdata_o), 32'(t - 1));
            end
            next_cycle();
        end
        for (int t = 0; t < 19; t++) begin
            clr_all();
            if (t < 16) drive(1, 1'b0, ADDR_W'(t), 8'h00);
            @(negedge clk);
            if (t < 16) chk("rd_gnt", 32'(bus.gnt_o), 32'b010);
            if (t >= 2 && t < 18) begin
                chk("rd_rvalid", 32'(bus.rvalid_o), 32'b010);
                chk("rd_data", 32'(bus.rdata_o), 32'(t - 2));
            end else begin
                chk("rd_norvalid", 32'(bus.rvalid_o), 0);
            end
            if (t == 18) chk("rd_idle_busy", 32'(bus.busy_o), 0);
            next_cycle();
        end

        // All three request continuously: 16-grant bursts rotating 0,1,2,0.
        do_reset();
        for (int c = 0; c < 52; c++) begin
            clr_all();
            for (int k = 0; k < N_REQ; k++) drive(k, 1'b0, ADDR_W'(k), 8'h00);
            @(negedge clk);
            chk("rr_gnt", 32'(bus.gnt_o), 32'(1) << ((c / 16) % 3));
            if (c >= 1) chk("rr_en", 32'(bus.ram_en_o), 1);
            if (c >= 2) begin
                chk("rr_rvalid", 32'(bus.rvalid_o), 32'(1) << (((c - 2) / 16) % 3));
                chk("rr_rdata", 32'(bus.rdata_o), 32'(((c - 2) / 16) % 3));
            end
            next_cycle();
        end

        // Owner 2 drops out; pointer must be at 0 afterwards.
        do_reset();
        clr_all();
        drive(2, 1'b1, 17'd100, 8'h11);
        @(negedge clk);
        chk("ptr_gnt2", 32'(bus.gnt_o), 32'b100);
        next_cycle();
        clr_all();
        @(negedge clk);
        chk("ptr_gap_gnt", 32'(bus.gnt_o), 0);
        chk("ptr_gap_state", 32'(bus.arb_state), 32'(ARB_OWN));
        next_cycle();
        clr_all();
        drive(0, 1'b1, 17'd101, 8'h22);
        drive(1, 1'b1, 17'd102, 8'h33);
        @(negedge clk);
        chk("ptr_gnt0", 32'(bus.gnt_o), 32'b001);
        chk("ptr_idle_state", 32'(bus.arb_state), 32'(ARB_IDLE));
        next_cycle();
        clr_all();
        drive(1, 1'b1, 17'd102, 8'h33);
        @(negedge clk);
        chk("ptr_gnt1", 32'(bus.gnt_o), 32'b010);
        next_cycle();

        // Out-of-range reads by requester 0.
        do_reset();
        clr_all();
        drive(0, 1'b0, 17'd76800, 8'h00);
        @(negedge clk);
        chk("oor_gnt", 32'(bus.gnt_o), 32'b001);
        next_cycle();
        clr_all();
        drive(0, 1'b0, 17'd131071, 8'h00);
        @(negedge clk);
        chk("oor_err1", 32'(bus.err_o), 32'b001);
        chk("oor_en1", 32'(bus.ram_en_o), 0);
        chk("oor_busy1", 32'(bus.busy_o), 1);
        next_cycle();
        clr_all();
        @(negedge clk);
        chk("oor_err2", 32'(bus.err_o), 32'b001);
        chk("oor_en2", 32'(bus.ram_en_o), 0);
        chk("oor_rvalid2", 32'(bus.rvalid_o), 32'b001);
        chk("oor_rdata2", 32'(bus.rdata_o), 0);
        next_cycle();
        @(negedge clk);
        chk("oor_err3", 32'(bus.err_o), 0);
        chk("oor_rvalid3", 32'(bus.rvalid_o), 32'b001);
        chk("oor_rdata3", 32'(bus.rdata_o), 0);
        next_cycle();
        @(negedge clk);
        chk("oor_rvalid4", 32'(bus.rvalid_o), 0);
        chk("oor_busy4", 32'(bus.busy_o), 0);
        next_cycle();

        // Reset while a read is in flight.
        do_reset();
        clr_all();
        drive(1, 1'b0, 17'd3, 8'h00);
        @(negedge clk);
        chk("mid_gnt", 32'(bus.gnt_o), 32'b010);
        next_cycle();
        rstn = 1'b0;
        clr_all();
        @(negedge clk);
        chk("mid_rvalid", 32'(bus.rvalid_o), 0);
        chk("mid_err", 32'(bus.err_o), 0);
        chk("mid_en", 32'(bus.ram_en_o), 0);
        chk("mid_busy", 32'(bus.busy_o), 0);
        chk("mid_rdata", 32'(bus.rdata_o), 0);
        chk("mid_state", 32'(bus.arb_state), 32'(ARB_IDLE));
        next_cycle();
        rstn = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("post_rvalid", 32'(bus.rvalid_o), 0);
            chk("post_err", 32'(bus.err_o), 0);
            chk("post_busy", 32'(bus.busy_o), 0);
            next_cycle();
        end

        // Write by 0 followed immediately by read of the same word by 2.
        do_reset();
        clr_all();
        drive(0, 1'b1, 17'd5, 8'hA5);
        @(negedge clk);
        chk("wr_rd_gnt0", 32'(bus.gnt_o), 32'b001);
        next_cycle();
        clr_all();
        drive(2, 1'b0, 17'd5, 8'h00);
        @(negedge clk);
        chk("wr_rd_gnt2", 32'(bus.gnt_o), 32'b100);
        chk("wr_rd_we", 32'(bus.ram_we_o), 1);
        chk("wr_rd_addr", 32'(bus.ram_addr_o), 5);
        next_cycle();
        clr_all();
        @(negedge clk);
        chk("wr_rd_norv", 32'(bus.rvalid_o), 0);
        next_cycle();
        @(negedge clk);
        chk("wr_rd_rvalid", 32'(bus.rvalid_o), 32'b100);
        chk("wr_rd_rdata", 32'(bus.rdata_o), 32'hA5);
        next_cycle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
